// File: rtl/obi_insn_responder.sv
// Instruction-side OBI responder: word-addressed ROM model with programmable grant stall,
// response latency, in-order outstanding transactions and initiator protocol checking.
module obi_insn_responder #(
  parameter int unsigned DEPTH           = 1024,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned GNT_STALL       = 0,
  parameter int unsigned RVALID_LAT      = 1,
  parameter logic [31:0] OOR_DATA        = 32'h0000_0013,
  localparam int unsigned AW             = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW             = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          instr_req_i,
  input  logic [31:0]   instr_addr_i,
  output logic          instr_gnt_o,
  output logic          instr_rvalid_o,
  output logic [31:0]   instr_rdata_o,
  input  logic          mem_we_i,
  input  logic [AW-1:0] mem_waddr_i,
  input  logic [31:0]   mem_wdata_i,
  output logic [CW-1:0] outstanding_o,
  output logic          proto_err_o
);

  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned SW = (GNT_STALL > 0) ? $clog2(GNT_STALL + 1) : 1;
  localparam int unsigned GW = $clog2(RVALID_LAT + 1);

  localparam logic [SW-1:0] STALL_SAT = SW'(GNT_STALL);
  localparam logic [GW-1:0] LAT_SAT   = GW'(RVALID_LAT);
  localparam logic [CW-1:0] CNT_MAX   = CW'(MAX_OUTSTANDING);

  logic [31:0]   rom [DEPTH];

  logic [AW-1:0] idx_q [MAX_OUTSTANDING];
  logic          oor_q [MAX_OUTSTANDING];
  logic [GW-1:0] age_q [MAX_OUTSTANDING];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic [SW-1:0] stall_q;
  logic          pend_q;
  logic [31:0]   paddr_q;
  logic          err_q;

  logic          push;
  logic          pop;
  logic          req_oor;

  // Circular pointer advance that wraps at the queue depth (need not be a power of two).
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  // Grant uses the registered count, so a same-cycle pop never frees a slot early.
  assign instr_gnt_o    = instr_req_i & (stall_q == STALL_SAT) & (count_q < CNT_MAX);
  assign instr_rvalid_o = (count_q != '0) & (age_q[rd_ptr_q] == LAT_SAT);
  assign push           = instr_req_i & instr_gnt_o;
  assign pop            = instr_rvalid_o;
  assign req_oor        = instr_addr_i[31:2] >= 30'(DEPTH);
  assign outstanding_o  = count_q;
  assign proto_err_o    = err_q;

  // Response data: head entry, constant for out-of-range words, zero when idle.
  always_comb begin
    instr_rdata_o = '0;
    if (instr_rvalid_o) begin
      instr_rdata_o = oor_q[rd_ptr_q] ? OOR_DATA : rom[idx_q[rd_ptr_q]];
    end
  end

  // Preload port; a read of the same word in this cycle still sees the old contents.
  always_ff @(posedge clk_i) begin
    if (mem_we_i) begin
      rom[mem_waddr_i] <= mem_wdata_i;
    end
  end

  // Transaction payload captured on acceptance.
  always_ff @(posedge clk_i) begin
    if (push) begin
      idx_q[wr_ptr_q] <= instr_addr_i[AW+1:2];
      oor_q[wr_ptr_q] <= req_oor;
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (!push && pop) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  // Entry ages: a new entry has already seen its grant edge, all others saturate at the latency.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
        if (push && (wr_ptr_q == PW'(i))) begin
          age_q[i] <= GW'(1);
        end else if (age_q[i] != LAT_SAT) begin
          age_q[i] <= age_q[i] + GW'(1);
        end
      end
    end
  end

  // Grant stall counter: counts unanswered request cycles, saturating at the stall value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
    end else if (instr_req_i && !instr_gnt_o) begin
      if (stall_q != STALL_SAT) stall_q <= stall_q + SW'(1);
    end else begin
      stall_q <= '0;
    end
  end

  // Protocol monitor: a pending request must stay asserted with a stable address.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q  <= 1'b0;
      paddr_q <= '0;
      err_q   <= 1'b0;
    end else begin
      pend_q  <= instr_req_i & ~instr_gnt_o;
      paddr_q <= instr_addr_i;
      if (pend_q && (!instr_req_i || (instr_addr_i != paddr_q))) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_obi_insn_responder.sv
// Bench for obi_insn_responder: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a transaction-level model.
module tb_obi_insn_responder;

  localparam int unsigned DEPTH      = 64;
  localparam int unsigned MAX_OUT    = 2;
  localparam int unsigned GNT_STALL  = 1;
  localparam int unsigned RVALID_LAT = 4;
  localparam logic [31:0] OOR        = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
  logic        mem_we = 1'b0;
  logic [5:0]  mem_waddr = '0;
  logic [31:0] mem_wdata = '0;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic [1:0]  outstanding;
  logic        proto_err;

  int checks = 0;
  int errors = 0;

  obi_insn_responder #(
    .DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT), .GNT_STALL(GNT_STALL),
    .RVALID_LAT(RVALID_LAT), .OOR_DATA(OOR)
  ) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(gnt), .instr_rvalid_o(rvalid), .instr_rdata_o(rdata),
    .mem_we_i(mem_we), .mem_waddr_i(mem_waddr), .mem_wdata_i(mem_wdata),
    .outstanding_o(outstanding), .proto_err_o(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    int unsigned t;
    bit          oor;
    int unsigned idx;
  } txn_t;

  txn_t        mq[$];
  logic [31:0] m_rom [DEPTH];
  int unsigned cyc = 0;
  int unsigned m_wait = 0;
  bit          m_pend = 0;
  logic [31:0] m_paddr = '0;
  bit          m_err = 0;
  bit          e_gnt;
  bit          e_rv;
  logic [31:0] e_rd;

  // Every cycle: predict outputs from the transaction list, compare, then advance the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_wait = 0;
      m_pend = 0;
      m_err  = 0;
      chk("model_rst_rvalid", 32'(rvalid), 32'd0);
      chk("model_rst_outstanding", 32'(outstanding), 32'd0);
      chk("model_rst_proto", 32'(proto_err), 32'd0);
    end else begin
      e_gnt = req && (m_wait >= GNT_STALL) && (mq.size() < int'(MAX_OUT));
      e_rv  = (mq.size() > 0) && (cyc >= mq[0].t + RVALID_LAT);
      e_rd  = '0;
      if (e_rv) e_rd = mq[0].oor ? OOR : m_rom[mq[0].idx];
      chk("model_gnt", 32'(gnt), 32'(e_gnt));
      chk("model_rvalid", 32'(rvalid), 32'(e_rv));
      chk("model_rdata", rdata, e_rd);
      chk("model_outstanding", 32'(outstanding), 32'(mq.size()));
      chk("model_proto", 32'(proto_err), 32'(m_err));
      if (m_pend && (!req || addr != m_paddr)) m_err = 1;
      m_pend  = req && !e_gnt;
      m_paddr = addr;
      if (e_rv) void'(mq.pop_front());
      if (req && e_gnt) mq.push_back('{t: cyc, oor: (addr[31:2] >= 30'(DEPTH)), idx: 32'(addr[7:2])});
      if (req && !e_gnt) m_wait++;
      else m_wait = 0;
      if (mem_we) m_rom[mem_waddr] = mem_wdata;
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic r, input logic [31:0] a, input logic we,
                      input logic [5:0] wa, input logic [31:0] wd);
    @(posedge clk);
    #1;
    req = r; addr = a; mem_we = we; mem_waddr = wa; mem_wdata = wd;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 32'h0, 1'b0, 6'd0, 32'h0);
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return $urandom;
    return (32'($urandom_range(0, 79)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  task automatic rand_phase(input int n);
    logic hold;
    for (int k = 0; k < n; k++) begin
      hold = req && !gnt;
      @(posedge clk);
      #1;
      if (!hold) begin
        req  = ($urandom_range(0, 99) < 65);
        addr = rand_addr();
      end
      mem_we    = ($urandom_range(0, 99) < 20);
      mem_waddr = 6'($urandom_range(0, 63));
      mem_wdata = $urandom;
      @(negedge clk);
    end
  endtask

  // Finish any pending request legally, then let the queue empty.
  task automatic drain();
    int k = 0;
    while (req && !gnt && k < 20) begin
      step(1'b1, addr, 1'b0, 6'd0, 32'h0);
      k++;
    end
    if (req && !gnt) chk("drain_grant_timeout", 32'd0, 32'd1);
    idle(10);
  endtask

  logic [31:0] d;

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_outstanding", 32'(outstanding), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Preload every word so ROM contents are fully known.
    for (int i = 0; i < int'(DEPTH); i++) begin
      case (i)
        0: d = 32'hA0A0_0000;
        1: d = 32'hA1A1_0001;
        2: d = 32'hA2A2_0002;
        4: d = 32'hDEAD_BEEF;
        default: d = $urandom;
      endcase
      step(1'b0, 32'h0, 1'b1, 6'(i), d);
    end
    chk("post_reset_rvalid", 32'(rvalid), 32'd0);
    chk("post_reset_proto", 32'(proto_err), 32'd0);

    // Single read: one stall cycle, then response RVALID_LAT cycles after the grant.
    step(1'b1, 32'h10, 1'b0, 6'd0, 32'h0); chk("d1_gnt_stalled", 32'(gnt), 32'd0);
    step(1'b1, 32'h10, 1'b0, 6'd0, 32'h0); chk("d1_gnt", 32'(gnt), 32'd1);
    chk("d1_outstanding_pre", 32'(outstanding), 32'd0);
    step(1'b0, 32'h0, 1'b0, 6'd0, 32'h0); chk("d1_outstanding_1", 32'(outstanding), 32'd1);
    idle(2);                               chk("d1_rvalid_early", 32'(rvalid), 32'd0);
    idle(1);                               chk("d1_rvalid", 32'(rvalid), 32'd1);
    chk("d1_rdata", rdata, 32'hDEAD_BEEF);
    idle(1);                               chk("d1_outstanding_0", 32'(outstanding), 32'd0);
    chk("d1_rdata_idle", rdata, 32'h0);

    // Back-to-back requests fill the queue; grant is withheld while full.
    step(1'b1, 32'h0, 1'b0, 6'd0, 32'h0); chk("d2_c0_gnt", 32'(gnt), 32'd0);
    step(1'b1, 32'h0, 1'b0, 6'd0, 32'h0); chk("d2_c1_gnt", 32'(gnt), 32'd1);
    step(1'b1, 32'h4, 1'b0, 6'd0, 32'h0); chk("d2_c2_gnt", 32'(gnt), 32'd0);
    step(1'b1, 32'h4, 1'b0, 6'd0, 32'h0); chk("d2_c3_gnt", 32'(gnt), 32'd1);
    step(1'b1, 32'h8, 1'b0, 6'd0, 32'h0); chk("d2_c4_outstanding", 32'(outstanding), 32'd2);
    step(1'b1, 32'h8, 1'b0, 6'd0, 32'h0); chk("d2_c5_gnt_full", 32'(gnt), 32'd0);
    chk("d2_c5_rdata", rdata, 32'hA0A0_0000);
    step(1'b1, 32'h8, 1'b0, 6'd0, 32'h0); chk("d2_c6_gnt", 32'(gnt), 32'd1);
    chk("d2_c6_outstanding", 32'(outstanding), 32'd1);
    step(1'b0, 32'h0, 1'b0, 6'd0, 32'h0); chk("d2_c7_rdata", rdata, 32'hA1A1_0001);
    idle(3);                              chk("d2_c10_rdata", rdata, 32'hA2A2_0002);
    idle(1);                              chk("d2_c11_outstanding", 32'(outstanding), 32'd0);

    // Same-cycle preload of the word being returned, then an out-of-range read.
    step(1'b1, 32'h10, 1'b0, 6'd0, 32'h0);
    step(1'b1, 32'h10, 1'b0, 6'd0, 32'h0); chk("d3_gnt", 32'(gnt), 32'd1);
    idle(3);
    step(1'b0, 32'h0, 1'b1, 6'd4, 32'h1234_5678); chk("d3_old_data", rdata, 32'hDEAD_BEEF);
    step(1'b1, 32'h100, 1'b0, 6'd0, 32'h0);
    step(1'b1, 32'h100, 1'b0, 6'd0, 32'h0); chk("d3_oor_gnt", 32'(gnt), 32'd1);
    step(1'b1, 32'h10, 1'b0, 6'd0, 32'h0);
    step(1'b1, 32'h10, 1'b0, 6'd0, 32'h0);
    idle(2);                               chk("d3_oor_rdata", rdata, OOR);
    idle(2);                               chk("d3_new_data", rdata, 32'h1234_5678);
    idle(2);

    rand_phase(3000);
    drain();

    // Request withdrawn before grant: sticky violation.
    step(1'b1, 32'h20, 1'b0, 6'd0, 32'h0); chk("d4_gnt_stalled", 32'(gnt), 32'd0);
    step(1'b0, 32'h0, 1'b0, 6'd0, 32'h0);  chk("d4_proto_before", 32'(proto_err), 32'd0);
    step(1'b0, 32'h0, 1'b0, 6'd0, 32'h0);  chk("d4_proto_set", 32'(proto_err), 32'd1);
    idle(3);                               chk("d4_proto_sticky", 32'(proto_err), 32'd1);

    // Reset with two transactions in flight.
    step(1'b1, 32'h0, 1'b0, 6'd0, 32'h0);
    step(1'b1, 32'h0, 1'b0, 6'd0, 32'h0);
    step(1'b1, 32'h4, 1'b0, 6'd0, 32'h0);
    step(1'b1, 32'h4, 1'b0, 6'd0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 6'd0, 32'h0);  chk("d5_outstanding_2", 32'(outstanding), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("d5_async_outstanding", 32'(outstanding), 32'd0);
    chk("d5_async_proto", 32'(proto_err), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      chk("d5_no_rvalid", 32'(rvalid), 32'd0);
      chk("d5_outstanding", 32'(outstanding), 32'd0);
      idle(1);
    end

    rand_phase(400);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
